atomrvcore_hazard_ctrl: RTL and testbench
=========================================

Name: atomrvcore_hazard_ctrl

Overview:
- Pipeline hazard controller for the atomRVCORE IF/ID/EX/WB pipeline.
- Keeps a shadow scoreboard of destination registers in flight and produces the fwd1/fwd2 operand-select codes consumed by the decode unit.
- Generates load-use stalls, taken-branch/jump flushes and a freeze while data memory is not ready.
- Sits beside the decode unit; its inputs are the decoded ID-stage fields and the EX-stage resolution signals.

Parameters:
- REG_ADRESS_WIDTH, 5, register index width.
- FLUSH_CYCLES, 1, cycles of flush after a taken branch/jump (1..3).
- FWD_EN, 1, 0 forces fwd codes to 0 and converts every RAW hit into a stall until the producer retires.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID-stage instruction valid.
- id_rs1_i  in  5  ID source register 1.
- id_rs2_i  in  5  ID source register 2.
- id_use_rs1_i  in  1  instruction reads rs1.
- id_use_rs2_i  in  1  instruction reads rs2.
- id_rd_i  in  5  ID destination register.
- id_rwr_en_i  in  1  ID writes the register file.
- id_dr_en_i  in  1  ID instruction is a load.
- ex_redirect_i  in  1  EX branch taken, JAL or JALR.
- dmem_ready_i  in  1  data memory has completed the outstanding access.
- fwd1_o  out  2  operand A select: 0 = regfile, 1 = EX result, 2 = WB data.
- fwd2_o  out  2  operand B select, same encoding.
- stall_if_o  out  1  hold PC and IF/ID.
- stall_id_o  out  1  hold ID inputs.
- bubble_ex_o  out  1  load NOP into ID/EX.
- flush_id_o  out  1  squash IF/ID contents.
- flush_ex_o  out  1  squash ID/EX contents.
- freeze_o  out  1  hold every pipeline register.

Behaviour:
- Scoreboard: two entries, EX and WB. Each entry holds {rd, wr, ld}.
  - When not frozen, each clock: WB <= EX, and EX <= ID fields.
  - EX takes a bubble instead (wr=0, ld=0) when id_valid_i=0, bubble_ex_o=1 or flush_ex_o=1.
- Match rule: a hit needs use_rsN=1, rsN!=0, entry.wr=1 and entry.rd==rsN.
- Forwarding (combinational, same cycle):
  - EX hit with ld=0 gives code 1.
  - Otherwise a WB hit gives code 2.
  - Otherwise 0.
  - EX takes priority over WB.
- Load-use: an EX hit with ld=1 and id_valid_i=1 asserts stall_if_o, stall_id_o and bubble_ex_o for exactly 1 cycle. The following cycle the load sits in WB and forwards with code 2.
- FSM states: RUN, FLUSH, MEM_WAIT.
  - RUN -> FLUSH when ex_redirect_i=1 and not frozen.
    - flush_id_o and flush_ex_o are asserted in the redirect cycle.
    - A down-counter loads FLUSH_CYCLES-1.
    - FLUSH keeps both flushes asserted until the counter reaches 0, then returns to RUN.
    - With FLUSH_CYCLES=1, FLUSH is left after one cycle and no extra flush cycle is added.
  - RUN/FLUSH -> MEM_WAIT when WB.ld=1 and dmem_ready_i=0.
    - freeze_o=1 in MEM_WAIT; the scoreboard, counter and fwd outputs hold.
    - Returns to the saved state on dmem_ready_i=1.
- Priority when events coincide: freeze > flush > load-use stall.
  - Redirect during freeze is held by the frozen EX stage and is acted on at release.
  - A load-use stall in a flush cycle is dropped.
- Reset (asynchronous, any time):
  - Scoreboard entries cleared (wr=0, ld=0, rd=0).
  - FSM in RUN, counter 0.
  - All outputs 0.
- Timing: all stall, flush and fwd outputs are combinational from registered state plus current inputs, with no added latency.

Optional Feature:
- Macro HZU_PERF_CNT_EN.
- When defined, adds outputs stall_cnt_o[31:0], flush_cnt_o[31:0] and freeze_cnt_o[31:0].
  - Each counter increments on every cycle its condition is asserted.
  - Each counter saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- When not defined, the ports and logic are absent.

Decomposition:
- Package atomrvcore_pkg holds:
  - fwd_sel_e enum (FWD_RF=0, FWD_EX=1, FWD_WB=2).
  - hzu_state_e enum (RUN, FLUSH, MEM_WAIT).
  - sb_entry_t struct {rd, wr, ld}.
- One sub-module, atomrvcore_hzu_match: the combinational rs-vs-scoreboard comparator. Instantiate it twice, once for rs1 and once for rs2.

Test Plan:
- add x3 then add x4,x3,x5 back-to-back -> fwd1_o=1, no stall. Next cycle, an instruction reading x3 -> fwd1_o=2.
- lw x6 then add x7,x6,x6 -> stall_if_o, stall_id_o and bubble_ex_o high for 1 cycle, then fwd1_o=fwd2_o=2.
- Writes to x0 followed by a read of x0 -> fwd codes 0, no stall.
- ex_redirect_i pulse with FLUSH_CYCLES=2 -> flush_id_o and flush_ex_o high for 2 cycles. Scoreboard EX entry is a bubble and the next instruction does not forward from the squashed one.
- Load in WB with dmem_ready_i=0 for 3 cycles, while ex_redirect_i=1 -> freeze_o high 3 cycles, flush deferred until release, then FSM enters FLUSH.
- rst_ni low mid-MEM_WAIT -> all outputs 0 immediately, FSM in RUN after release. With HZU_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/atomrvcore_pkg.sv
// rtl/atomrvcore_pkg.sv - shared types for the atomRVCORE hazard controller
// Purpose: operand-select codes, controller FSM states, scoreboard entry type
//          and the register-match helper used by the comparator.
// Ports:   none (package).
package atomrvcore_pkg;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned FLUSH_CNT_W = 2;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hzu_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } sb_entry_t;

  // x0 is hard-wired zero, so it can never carry a dependency.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_AW-1:0] rs,
                                  input logic use_rs);
    return use_rs && (rs != '0) && e.wr && (e.rd == rs);
  endfunction

endpackage

// File: rtl/atomrvcore_hzu_match.sv
// rtl/atomrvcore_hzu_match.sv - one source operand compared against the scoreboard
// Purpose: decides whether a source register depends on the EX or WB entry and
//          picks the operand-select code (EX priority over WB).
// Ports:   use_i, rs_i        source operand usage and index
//          ex_i, wb_i         scoreboard entries
//          raw_hit_o          any dependency on an in-flight producer
//          load_use_o         dependency on a load still in EX
//          sel_o              forwarding select for this operand
module atomrvcore_hzu_match
  import atomrvcore_pkg::*;
(
  input  logic              use_i,
  input  logic [REG_AW-1:0] rs_i,
  input  sb_entry_t         ex_i,
  input  sb_entry_t         wb_i,
  output logic              raw_hit_o,
  output logic              load_use_o,
  output fwd_sel_e          sel_o
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit     = sb_hit(ex_i, rs_i, use_i);
  assign wb_hit     = sb_hit(wb_i, rs_i, use_i);
  assign raw_hit_o  = ex_hit | wb_hit;
  assign load_use_o = ex_hit & ex_i.ld;

  // A load in EX has no data yet, so it falls through to the WB check.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit && !ex_i.ld) begin
      sel_o = FWD_EX;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/atomrvcore_hazard_ctrl.sv
// rtl/atomrvcore_hazard_ctrl.sv - IF/ID/EX/WB hazard controller (forwarding, stalls, flushes, freeze)
// Purpose: shadow scoreboard of in-flight destinations, forwarding selects,
//          load-use stall, redirect flush and data-memory freeze.
// Ports:   clk_i, rst_ni                          clock, async active-low reset
//          id_valid_i, id_rs1_i, id_rs2_i,
//          id_use_rs1_i, id_use_rs2_i, id_rd_i,
//          id_rwr_en_i, id_dr_en_i                decoded ID-stage fields
//          ex_redirect_i                          taken branch / jump in EX
//          dmem_ready_i                           data memory access complete
//          fwd1_o, fwd2_o                         operand selects (0 RF, 1 EX, 2 WB)
//          stall_if_o, stall_id_o, bubble_ex_o    load-use stall controls
//          flush_id_o, flush_ex_o                 redirect squash controls
//          freeze_o                               hold every pipeline register
//          stall_cnt_o, flush_cnt_o, freeze_cnt_o saturating event counters,
//                                                 present only with HZU_PERF_CNT_EN
module atomrvcore_hazard_ctrl
  import atomrvcore_pkg::*;
#(
  parameter int unsigned REG_ADRESS_WIDTH = 5,
  parameter int unsigned FLUSH_CYCLES     = 1,
  parameter bit          FWD_EN           = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        id_valid_i,
  input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
  input  logic                        id_use_rs1_i,
  input  logic                        id_use_rs2_i,
  input  logic [REG_ADRESS_WIDTH-1:0] id_rd_i,
  input  logic                        id_rwr_en_i,
  input  logic                        id_dr_en_i,
  input  logic                        ex_redirect_i,
  input  logic                        dmem_ready_i,
  output logic [1:0]                  fwd1_o,
  output logic [1:0]                  fwd2_o,
  output logic                        stall_if_o,
  output logic                        stall_id_o,
  output logic                        bubble_ex_o,
  output logic                        flush_id_o,
  output logic                        flush_ex_o,
  output logic                        freeze_o
`ifdef HZU_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 flush_cnt_o,
  output logic [31:0]                 freeze_cnt_o
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  sb_entry_t             ex_q, wb_q;
  hzu_state_e            state_q, state_d;
  hzu_state_e            saved_q, saved_d;
  hzu_state_e            eff_state;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;

  logic     raw1, raw2, lu1, lu2;
  fwd_sel_e sel1, sel2;
  logic     freeze, flush, stall, hazard;

  atomrvcore_hzu_match u_match_rs1 (
    .use_i      (id_use_rs1_i),
    .rs_i       (id_rs1_i),
    .ex_i       (ex_q),
    .wb_i       (wb_q),
    .raw_hit_o  (raw1),
    .load_use_o (lu1),
    .sel_o      (sel1)
  );

  atomrvcore_hzu_match u_match_rs2 (
    .use_i      (id_use_rs2_i),
    .rs_i       (id_rs2_i),
    .ex_i       (ex_q),
    .wb_i       (wb_q),
    .raw_hit_o  (raw2),
    .load_use_o (lu2),
    .sel_o      (sel2)
  );

  // The scoreboard holds while frozen, so WB.ld stays set for the whole wait
  // and the freeze drops in the same cycle the memory reports ready.
  assign freeze = wb_q.ld & ~dmem_ready_i;

  // Without forwarding every dependency waits until its producer retires.
  assign hazard = FWD_EN ? (lu1 | lu2) : (raw1 | raw2);
  assign stall  = id_valid_i & hazard & ~freeze & ~flush;

  assign fwd1_o      = FWD_EN ? sel1 : FWD_RF;
  assign fwd2_o      = FWD_EN ? sel2 : FWD_RF;
  assign stall_if_o  = stall;
  assign stall_id_o  = stall;
  assign bubble_ex_o = stall;
  assign flush_id_o  = flush;
  assign flush_ex_o  = flush;
  assign freeze_o    = freeze;

  // MEM_WAIT remembers the interrupted state; on release the cycle behaves as
  // that state would, so a redirect held in the frozen EX stage is taken then.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    flush     = 1'b0;
    eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    if (freeze) begin
      if (state_q != MEM_WAIT) begin
        saved_d = state_q;
        state_d = MEM_WAIT;
      end
    end else if (eff_state == FLUSH && cnt_q != '0) begin
      flush   = 1'b1;
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == FLUSH_CNT_W'(1)) ? RUN : FLUSH;
    end else if (ex_redirect_i) begin
      // With a single flush cycle the counter loads 0 and FLUSH exits at once.
      flush   = 1'b1;
      cnt_d   = FLUSH_LOAD;
      state_d = FLUSH;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q <= '0;
      wb_q <= '0;
    end else if (!freeze) begin
      wb_q <= ex_q;
      if (id_valid_i && !stall && !flush) begin
        ex_q <= '{rd: REG_AW'(id_rd_i), wr: id_rwr_en_i, ld: id_dr_en_i};
      end else begin
        ex_q <= '0;
      end
    end
  end

`ifdef HZU_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      freeze_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush && flush_cnt_o != '1) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
      if (freeze && freeze_cnt_o != '1) begin
        freeze_cnt_o <= freeze_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_atomrvcore_hazard_ctrl.sv
// tb/tb_atomrvcore_hazard_ctrl.sv - directed self-checking bench for atomrvcore_hazard_ctrl
module tb_atomrvcore_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic       id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
  logic       id_rwr_en_i = 1'b0, id_dr_en_i = 1'b0;
  logic       ex_redirect_i = 1'b0;
  logic       dmem_ready_i = 1'b1;
  logic [1:0] fwd1_o, fwd2_o;
  logic       stall_if_o, stall_id_o, bubble_ex_o, flush_id_o, flush_ex_o, freeze_o;
`ifdef HZU_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o, freeze_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  atomrvcore_hazard_ctrl #(
    .REG_ADRESS_WIDTH (5),
    .FLUSH_CYCLES     (2),
    .FWD_EN           (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_rwr_en_i   (id_rwr_en_i),
    .id_dr_en_i    (id_dr_en_i),
    .ex_redirect_i (ex_redirect_i),
    .dmem_ready_i  (dmem_ready_i),
    .fwd1_o        (fwd1_o),
    .fwd2_o        (fwd2_o),
    .stall_if_o    (stall_if_o),
    .stall_id_o    (stall_id_o),
    .bubble_ex_o   (bubble_ex_o),
    .flush_id_o    (flush_id_o),
    .flush_ex_o    (flush_ex_o),
    .freeze_o      (freeze_o)
`ifdef HZU_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
    .freeze_cnt_o  (freeze_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [9:0] outs;
  assign outs = {fwd1_o, fwd2_o, stall_if_o, stall_id_o, bubble_ex_o,
                 flush_id_o, flush_ex_o, freeze_o};

  // Expected output word: {fwd1, fwd2, stall x3, flush x2, freeze}.
  function automatic logic [31:0] exp_o(input logic [1:0] f1, input logic [1:0] f2,
                                        input logic st, input logic fl, input logic fz);
    return {22'd0, f1, f2, st, st, st, fl, fl, fz};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    id_valid_i   = v;
    id_rs1_i     = rs1;
    id_use_rs1_i = u1;
    id_rs2_i     = rs2;
    id_use_rs2_i = u2;
    id_rd_i      = rd;
    id_rwr_en_i  = wr;
    id_dr_en_i   = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #3;
    check_eq("reset_outs", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
    tick();
    rst_ni = 1'b1;

    // add x3 ; add x4,x3,x5 ; reader of x3 (rs1) and x4 (rs2)
    id_set(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    check_eq("add_x3", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
    tick();
    id_set(1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0);
    check_eq("fwd_ex", {22'd0, outs}, exp_o(1, 0, 0, 0, 0));
    tick();
    id_set(1, 5'd3, 1, 5'd4, 1, 5'd0, 0, 0);
    check_eq("fwd_wb_ex", {22'd0, outs}, exp_o(2, 1, 0, 0, 0));
    tick();

    // lw x6 (base x4 from WB) ; add x7,x6,x6 -> one stall, then WB forward
    id_set(1, 5'd4, 1, 5'd6, 0, 5'd6, 1, 1);
    check_eq("lw_base", {22'd0, outs}, exp_o(2, 0, 0, 0, 0));
    tick();
    id_set(1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0);
    check_eq("load_use", {22'd0, outs}, exp_o(0, 0, 1, 0, 0));
    tick();
    check_eq("after_stall", {22'd0, outs}, exp_o(2, 2, 0, 0, 0));
    tick();

    // writes to x0 (ALU and load) never create dependencies
    id_set(1, 5'd7, 1, 5'd0, 1, 5'd0, 1, 0);
    check_eq("x0_write", {22'd0, outs}, exp_o(1, 0, 0, 0, 0));
    tick();
    id_set(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1);
    check_eq("x0_read", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
    tick();
    id_set(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
    check_eq("x0_load_use", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
    tick();

    // redirect with two flush cycles; squashed writers must not forward
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0);
    ex_redirect_i = 1'b1;
    #1;
    check_eq("flush_1", {22'd0, outs}, exp_o(0, 0, 0, 1, 0));
    tick();
    ex_redirect_i = 1'b0;
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    check_eq("flush_2", {22'd0, outs}, exp_o(0, 0, 0, 1, 0));
    tick();
    id_set(1, 5'd8, 1, 5'd9, 1, 5'd0, 0, 0);
    check_eq("post_flush", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
    tick();

    // load reaches WB with memory busy 3 cycles while a redirect is pending
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
    tick();
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0);
    tick();
    id_set(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0);
    dmem_ready_i  = 1'b0;
    ex_redirect_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("freeze_%0d", i), {22'd0, outs}, exp_o(1, 0, 0, 0, 1));
      tick();
    end
    dmem_ready_i = 1'b1;
    #1;
    check_eq("release_flush", {22'd0, outs}, exp_o(1, 0, 0, 1, 0));
    tick();
    ex_redirect_i = 1'b0;
    #1;
    check_eq("release_flush2", {22'd0, outs}, exp_o(2, 0, 0, 1, 0));
    tick();
    check_eq("release_run", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));

    // asynchronous reset while waiting on memory
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1);
    tick();
    id_set(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    tick();
    id_set(1, 5'd13, 1, 5'd0, 0, 5'd0, 0, 0);
    dmem_ready_i = 1'b0;
    #1;
    check_eq("pre_reset_freeze", {22'd0, outs}, exp_o(2, 0, 0, 0, 1));
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("reset_async", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
`ifdef HZU_PERF_CNT_EN
    check_eq("stall_cnt_rst", stall_cnt_o, 32'd0);
    check_eq("flush_cnt_rst", flush_cnt_o, 32'd0);
    check_eq("freeze_cnt_rst", freeze_cnt_o, 32'd0);
`endif
    tick();
    rst_ni = 1'b1;
    tick();
    check_eq("reset_run", {22'd0, outs}, exp_o(0, 0, 0, 0, 0));
    ex_redirect_i = 1'b1;
    #1;
    check_eq("reset_redirect", {22'd0, outs}, exp_o(0, 0, 0, 1, 0));
    tick();
    ex_redirect_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
